vga_fb_scanout: RTL and testbench

//  Pixel source directly upstream of vga_driver: holds a FB_W x FB_H RGB332 framebuffer and converts
//  the driver's hcount/vcount into 8-bit R/G/B with fixed 2-cycle latency (each FB pixel is drawn
//  as a 2^SCALE_LOG2 square). The 8-bit CPU writes pixels through a 4-register pointer interface and
//  can start a hardware clear. Dual-port internal RAM: port A is scanout read, port B is CPU/clear write.

---
 rtl/vga_fb_scanout.sv | 151 +++++++++++++++
 tb/tb_vga_fb_scanout.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_scanout.sv
// RGB332 framebuffer feeding vga_driver: two-stage scanout pipeline on RAM port A,
// CPU pointer/data writes and hardware clear on RAM port B.
module vga_fb_scanout #(
  parameter int unsigned H_RES      = 640,
  parameter int unsigned V_RES      = 480,
  parameter int unsigned SCALE_LOG2 = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       cpu_we,
  input  logic [1:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] cpu_rdata,
  output logic       cpu_busy,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b
);

  localparam int unsigned FbW    = H_RES >> SCALE_LOG2;
  localparam int unsigned FbH    = V_RES >> SCALE_LOG2;
  localparam int unsigned FbSize = FbW * FbH;

  typedef enum logic {StIdle, StClear} state_e;

  state_e      state_q, state_d;
  logic [14:0] clr_cnt_q, clr_cnt_d;
  logic [7:0]  x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic        disp_en_q, disp_en_d;

  logic        ram_we;
  logic [14:0] ram_waddr;
  logic [7:0]  ram_wdata;
  logic [7:0]  mem [FbSize];

  logic        in_range;
  logic [14:0] pix_waddr;

  assign in_range  = (x_q < 8'(FbW)) && (y_q < 7'(FbH));
  assign pix_waddr = 15'(y_q) * 15'(FbW) + 15'(x_q);
  assign cpu_busy  = (state_q == StClear);

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    x_d       = x_q;
    y_d       = y_q;
    disp_en_d = disp_en_q;
    ram_we    = 1'b0;
    ram_waddr = pix_waddr;
    ram_wdata = cpu_wdata;

    if (cpu_we) begin
      case (cpu_addr)
        2'd0: x_d = cpu_wdata;
        2'd1: y_d = cpu_wdata[6:0];
        2'd2: begin
          if (state_q == StIdle) begin
            // Out-of-range pointers still advance so the CPU can stream blindly.
            ram_we = in_range;
            if (x_q >= 8'(FbW - 1)) begin
              x_d = 8'd0;
              y_d = (y_q >= 7'(FbH - 1)) ? 7'd0 : y_q + 7'd1;
            end else begin
              x_d = x_q + 8'd1;
            end
          end
        end
        default: begin
          disp_en_d = cpu_wdata[0];
          if (cpu_wdata[1] && state_q == StIdle) begin
            state_d   = StClear;
            clr_cnt_d = 15'd0;
          end
        end
      endcase
    end

    if (state_q == StClear) begin
      ram_we    = 1'b1;
      ram_waddr = clr_cnt_q;
      ram_wdata = 8'h00;
      clr_cnt_d = clr_cnt_q + 15'd1;
      if (clr_cnt_q == 15'(FbSize - 1)) state_d = StIdle;
    end
  end

  always_comb begin
    cpu_rdata = 8'h00;
    case (cpu_addr)
      2'd0:    cpu_rdata = x_q;
      2'd1:    cpu_rdata = {1'b0, y_q};
      2'd2:    cpu_rdata = 8'h00;
      default: cpu_rdata = {6'b0, cpu_busy, disp_en_q};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      clr_cnt_q <= 15'd0;
      x_q       <= 8'd0;
      y_q       <= 7'd0;
      disp_en_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      disp_en_q <= disp_en_d;
    end
  end

  // Port B write; a scanout read of the same address sees the old byte.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
  end

  logic [14:0] scan_addr, addr_q;
  logic        active, active_q;
  logic [7:0]  pix;
  logic [2:0]  r3, g3;
  logic [1:0]  b2;

  assign scan_addr = 15'(vcount >> SCALE_LOG2) * 15'(FbW) + 15'(hcount >> SCALE_LOG2);
  assign active    = (hcount < 10'(H_RES)) && (vcount < 10'(V_RES)) && disp_en_q;
  assign pix       = mem[addr_q];
  assign r3        = pix[7:5];
  assign g3        = pix[4:2];
  assign b2        = pix[1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q   <= 15'd0;
      active_q <= 1'b0;
      vga_r    <= 8'h00;
      vga_g    <= 8'h00;
      vga_b    <= 8'h00;
    end else begin
      addr_q   <= scan_addr;
      active_q <= active;
      vga_r    <= active_q ? {r3, r3, r3[2:1]} : 8'h00;
      vga_g    <= active_q ? {g3, g3, g3[2:1]} : 8'h00;
      vga_b    <= active_q ? {b2, b2, b2, b2}  : 8'h00;
    end
  end

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Directed bench for vga_fb_scanout: pixel probe tables plus clear, reset-abort and pointer
// wrap sequences.
module tb_vga_fb_scanout;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] hcount = '0;
  logic [9:0] vcount = '0;
  logic       cpu_we = 1'b0;
  logic [1:0] cpu_addr = '0;
  logic [7:0] cpu_wdata = '0;
  logic [7:0] cpu_rdata;
  logic       cpu_busy;
  logic [7:0] vga_r, vga_g, vga_b;

  vga_fb_scanout dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .hcount    (hcount),
    .vcount    (vcount),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_busy  (cpu_busy),
    .vga_r     (vga_r),
    .vga_g     (vga_g),
    .vga_b     (vga_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  h;
    logic [9:0]  v;
    logic [23:0] rgb;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    @(negedge clk);
    cpu_we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    cpu_addr = a;
    #1;
    d = cpu_rdata;
  endtask

  task automatic probe(input string name, input logic [9:0] h, input logic [9:0] v,
                       input logic [23:0] exp);
    hcount = h; vcount = v;
    @(negedge clk);
    @(negedge clk);
    chk(name, {vga_r, vga_g, vga_b}, exp);
  endtask

  task automatic wait_idle(input string name);
    int c = 0;
    while (cpu_busy && c < 30000) begin
      c++;
      @(negedge clk);
    end
    chk(name, cpu_busy, 0);
  endtask

  vec_t tab1[12];
  vec_t tab2[6];

  initial begin
    logic [7:0] d;
    int cnt;
    int bad;

    tab1[0]  = '{10'd20,  10'd12,  24'hFF0000};
    tab1[1]  = '{10'd23,  10'd15,  24'hFF0000};
    tab1[2]  = '{10'd21,  10'd14,  24'hFF0000};
    tab1[3]  = '{10'd24,  10'd12,  24'h000000};
    tab1[4]  = '{10'd19,  10'd12,  24'h000000};
    tab1[5]  = '{10'd20,  10'd16,  24'h000000};
    tab1[6]  = '{10'd636, 10'd476, 24'h00FF00};
    tab1[7]  = '{10'd639, 10'd479, 24'h00FF00};
    tab1[8]  = '{10'd0,   10'd0,   24'h0000FF};
    tab1[9]  = '{10'd3,   10'd3,   24'h0000FF};
    tab1[10] = '{10'd4,   10'd0,   24'h000000};
    tab1[11] = '{10'd635, 10'd476, 24'h000000};

    tab2[0] = '{10'd0,   10'd0,   24'h9292AA};
    tab2[1] = '{10'd3,   10'd3,   24'h9292AA};
    tab2[2] = '{10'd0,   10'd4,   24'h9292AA};
    tab2[3] = '{10'd640, 10'd0,   24'h000000};
    tab2[4] = '{10'd0,   10'd480, 24'h000000};
    tab2[5] = '{10'd639, 10'd479, 24'h00FF00};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_rgb", {vga_r, vga_g, vga_b}, 0);
    chk("reset_busy", cpu_busy, 0);
    rd(2'd0, d); chk("reset_x", d, 8'd0);
    rd(2'd1, d); chk("reset_y", d, 8'd0);
    rd(2'd3, d); chk("reset_ctrl", d, 8'h01);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    wr(2'd3, 8'h03);
    wait_idle("init_clear_done");

    // Red pixel, then green at the last pixel and blue after the wrap to (0,0)
    wr(2'd0, 8'd5); wr(2'd1, 8'd3); wr(2'd2, 8'hE0);
    wr(2'd0, 8'd159); wr(2'd1, 8'd119); wr(2'd2, 8'h1C); wr(2'd2, 8'h03);
    rd(2'd0, d); chk("wrap_x", d, 8'd1);
    rd(2'd1, d); chk("wrap_y", d, 8'd0);
    rd(2'd2, d); chk("data_rb", d, 8'h00);
    @(negedge clk);
    for (int i = 0; i < 12; i++) probe($sformatf("tab1[%0d]", i), tab1[i].h, tab1[i].v, tab1[i].rgb);

    // Latency: a change of coordinate is visible only after the second rising edge
    probe("lat_pre", 10'd20, 10'd12, 24'hFF0000);
    hcount = 10'd24;
    @(negedge clk);
    chk("lat_1edge", {vga_r, vga_g, vga_b}, 24'hFF0000);
    @(negedge clk);
    chk("lat_2edge", {vga_r, vga_g, vga_b}, 24'h000000);

    // Colour expansion, active-area gating and display enable
    wr(2'd0, 8'd0); wr(2'd1, 8'd0); wr(2'd2, 8'h92);
    wr(2'd0, 8'd0); wr(2'd1, 8'd1); wr(2'd2, 8'h92);
    for (int i = 0; i < 6; i++) probe($sformatf("tab2[%0d]", i), tab2[i].h, tab2[i].v, tab2[i].rgb);
    wr(2'd3, 8'h00);
    probe("disp_off", 10'd0, 10'd0, 24'h000000);
    rd(2'd3, d); chk("disp_off_rb", d, 8'h00);
    @(negedge clk);
    wr(2'd3, 8'h01);
    probe("disp_on", 10'd0, 10'd0, 24'h9292AA);

    // Full clear with a dropped DATA write while busy
    wr(2'd0, 8'd10); wr(2'd1, 8'd20);
    wr(2'd3, 8'h03);
    cnt = 0;
    while (cpu_busy && cnt < 25000) begin
      cnt++;
      if (cnt == 1) chk("busy_ctrl_rb", cpu_rdata, 8'h03);
      cpu_we = (cnt == 5);
      cpu_addr = (cnt == 5) ? 2'd2 : 2'd3;
      cpu_wdata = 8'hFF;
      @(negedge clk);
    end
    cpu_we = 1'b0;
    chk("busy_cycles", cnt, 19200);
    rd(2'd0, d); chk("busy_x_kept", d, 8'd10);
    rd(2'd1, d); chk("busy_y_kept", d, 8'd20);
    @(negedge clk);
    bad = 0;
    for (int y = 0; y < 120; y += 7) begin
      for (int x = 0; x < 160; x += 13) begin
        hcount = 10'(x * 4 + 1); vcount = 10'(y * 4 + 2);
        @(negedge clk); @(negedge clk);
        if ({vga_r, vga_g, vga_b} != 24'h0) bad++;
      end
    end
    chk("clear_sweep_nonzero", bad, 0);
    probe("clear_last", 10'd636, 10'd476, 24'h000000);
    probe("clear_first", 10'd0, 10'd0, 24'h000000);

    // Out-of-range X: write dropped, pointer still advances
    wr(2'd0, 8'd200); wr(2'd1, 8'd5); wr(2'd2, 8'hFF);
    rd(2'd0, d); chk("oor_x", d, 8'd0);
    rd(2'd1, d); chk("oor_y", d, 8'd6);
    @(negedge clk);
    probe("oor_no_write", 10'd160, 10'd24, 24'h000000);

    // Reset asserted 100 cycles into a clear
    wr(2'd0, 8'd159); wr(2'd1, 8'd119); wr(2'd2, 8'h1C);
    wr(2'd0, 8'd7); wr(2'd1, 8'd9);
    probe("pre_abort_green", 10'd636, 10'd476, 24'h00FF00);
    wr(2'd3, 8'h03);
    repeat (99) @(negedge clk);
    chk("mid_clear_busy", cpu_busy, 1);
    chk("mid_clear_rgb", {vga_r, vga_g, vga_b}, 24'h00FF00);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_busy", cpu_busy, 0);
    chk("abort_rgb", {vga_r, vga_g, vga_b}, 24'h000000);
    @(negedge clk);
    rd(2'd0, d); chk("abort_x", d, 8'd0);
    rd(2'd1, d); chk("abort_y", d, 8'd0);
    rd(2'd3, d); chk("abort_ctrl", d, 8'h01);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_abort_busy", cpu_busy, 0);
    probe("abort_tail_kept", 10'd636, 10'd476, 24'h00FF00);
    probe("abort_head_cleared", 10'd0, 10'd0, 24'h000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
